// File: rtl/stage4_lsu.sv
// stage4_lsu: memory stage that captures one instruction per unstalled cycle and runs at most one bus access.
// Ports: clk_i/rst_i (async active-high); alu_i, store_data_i, control_load_i, control_store_i, size_i, signed_i,
// do_wb_i, wb_reg_i from the previous stage; stall_o back upstream; mem_* request/response bus;
// do_wb_o, wb_reg_o, wb_val_o writeback; bus_err_o timeout pulse.
// Macro MISALIGN_TRAP_EN adds misalign_o and traps misaligned accesses instead of aligning them down.
module stage4_lsu #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           alu_i,
  input  logic [31:0]           store_data_i,
  input  logic                  control_load_i,
  input  logic                  control_store_i,
  input  logic [1:0]            size_i,
  input  logic                  signed_i,
  input  logic                  do_wb_i,
  input  logic [4:0]            wb_reg_i,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  do_wb_o,
  output logic [4:0]            wb_reg_o,
  output logic [31:0]           wb_val_o,
`ifdef MISALIGN_TRAP_EN
  output logic                  misalign_o,
`endif
  output logic                  bus_err_o
);
  localparam logic [0:0] IDLE = 1'b0, ACCESS = 1'b1;
  logic [0:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [31:0] alu_q, alu_d, sd_q, sd_d;
  logic ld_q, ld_d, st_q, st_d, sgn_q, sgn_d, wb_q, wb_d;
  logic [1:0] size_q, size_d;
  logic [4:0] reg_q, reg_d;
  logic access, timeout, mis_i, mis_q;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0] sh;
  assign access  = state_q == ACCESS;
  assign timeout = access && !mem_ack_i && cnt_q == 8'(TIMEOUT_CYCLES);
  assign stall_o = access && !mem_ack_i && !timeout;
`ifdef MISALIGN_TRAP_EN
  assign mis_i      = (control_load_i | control_store_i) && (size_i == 2'b01 ? alu_i[0] : (size_i[1] && |alu_i[1:0]));
  assign mis_q      = (ld_q | st_q) && (size_q == 2'b01 ? alu_q[0] : (size_q[1] && |alu_q[1:0]));
  assign misalign_o = mis_q;
  assign addr       = alu_q[ADDR_WIDTH-1:0];
`else
  assign mis_i = 1'b0;
  assign mis_q = 1'b0;
  // halves drop bit 0, words drop bits 1:0
  assign addr  = {alu_q[ADDR_WIDTH-1:2], size_q[1] ? 1'b0 : alu_q[1], size_q != 2'b00 ? 1'b0 : alu_q[0]};
`endif
  assign mem_req_o   = access;
  assign mem_we_o    = st_q;
  assign mem_addr_o  = addr;
  assign mem_be_o    = size_q[1] ? 4'b1111 : size_q[0] ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr[1:0];
  assign mem_wdata_o = size_q[1] ? sd_q : size_q[0] ? {2{sd_q[15:0]}} : {4{sd_q[7:0]}};
  assign sh          = 16'(mem_rdata_i >> {addr[1:0], 3'b000});
  assign wb_val_o    = ld_q ? (size_q[1] ? mem_rdata_i : size_q[0] ? {{16{sgn_q & sh[15]}}, sh} : {{24{sgn_q & sh[7]}}, sh[7:0]})
                     : st_q ? '0 : alu_q;
  assign bus_err_o   = timeout;
  assign do_wb_o     = wb_q && !stall_o && !timeout && !mis_q;
  assign wb_reg_o    = reg_q;
  // a completing access also accepts the next instruction, which may start a new access at once
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    alu_d   = alu_q;
    sd_d    = sd_q;
    ld_d    = ld_q;
    st_d    = st_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    wb_d    = wb_q;
    reg_d   = reg_q;
    if (!stall_o) begin
      state_d = ((control_load_i | control_store_i) && !mis_i) ? ACCESS : IDLE;
      cnt_d   = '0;
      alu_d   = alu_i;
      sd_d    = store_data_i;
      ld_d    = control_load_i;
      st_d    = control_store_i & ~control_load_i;
      size_d  = size_i;
      sgn_d   = signed_i;
      wb_d    = do_wb_i;
      reg_d   = wb_reg_i;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      alu_q   <= '0;
      sd_q    <= '0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      wb_q    <= 1'b0;
      reg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alu_q   <= alu_d;
      sd_q    <= sd_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      wb_q    <= wb_d;
      reg_q   <= reg_d;
    end
  end
endmodule

// File: tb/tb_stage4_lsu.sv
// tb_stage4_lsu: vector table, directed corner sequences and a randomized run against a behavioural model.
module tb_stage4_lsu;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] alu_i, store_data_i, mem_rdata_i, mem_wdata_o, wb_val_o, mem_addr_o;
  logic control_load_i, control_store_i, signed_i, do_wb_i, mem_ack_i;
  logic [1:0] size_i;
  logic [4:0] wb_reg_i, wb_reg_o;
  logic stall_o, mem_req_o, mem_we_o, do_wb_o, bus_err_o;
  logic [3:0] mem_be_o;
`ifdef MISALIGN_TRAP_EN
  logic misalign_o;
`endif
  int n_cmp = 0, n_bad = 0;

  stage4_lsu #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst), .alu_i(alu_i), .store_data_i(store_data_i),
    .control_load_i(control_load_i), .control_store_i(control_store_i), .size_i(size_i),
    .signed_i(signed_i), .do_wb_i(do_wb_i), .wb_reg_i(wb_reg_i), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .do_wb_o(do_wb_o), .wb_reg_o(wb_reg_o), .wb_val_o(wb_val_o),
`ifdef MISALIGN_TRAP_EN
    .misalign_o(misalign_o),
`endif
    .bus_err_o(bus_err_o));

  always #5 clk = ~clk;

  typedef struct {
    bit ld, st, sgn, wb;
    logic [1:0] size;
    logic [31:0] alu, sd;
    logic [4:0] rg;
  } op_t;
  typedef struct {
    op_t o;
    logic [31:0] rd;
    bit req, we;
    logic [31:0] addr, wdata, val;
    logic [3:0] be;
  } vec_t;

  function automatic op_t mkop(bit ld, bit st, logic [1:0] size, bit sgn, bit wb, logic [31:0] alu, logic [31:0] sd, logic [4:0] rg);
    op_t o;
    o.ld = ld; o.st = st; o.size = size; o.sgn = sgn; o.wb = wb; o.alu = alu; o.sd = sd; o.rg = rg;
    return o;
  endfunction
  function automatic vec_t mkv(op_t o, logic [31:0] rd, bit req, bit we, logic [31:0] addr, logic [3:0] be, logic [31:0] wdata, logic [31:0] val);
    vec_t v;
    v.o = o; v.rd = rd; v.req = req; v.we = we; v.addr = addr; v.be = be; v.wdata = wdata; v.val = val;
    return v;
  endfunction

  // behavioural reference: arithmetic on addresses and lanes
  function automatic bit isst(op_t o); return o.st && !o.ld; endfunction
  function automatic bit misal(op_t o);
`ifdef MISALIGN_TRAP_EN
    if (!(o.ld || o.st)) return 0;
    if (o.size == 1) return o.alu % 2 != 0;
    if (o.size >= 2) return o.alu % 4 != 0;
`endif
    return 0;
  endfunction
  function automatic logic [31:0] align(op_t o);
    if (o.size == 1) return o.alu - o.alu % 2;
    if (o.size >= 2) return o.alu - o.alu % 4;
    return o.alu;
  endfunction
  function automatic logic [3:0] m_be(op_t o);
    logic [31:0] a = align(o);
    if (o.size >= 2) return 4'd15;
    if (o.size == 1) return (a % 4 >= 2) ? 4'd12 : 4'd3;
    return 4'(1 << (a % 4));
  endfunction
  function automatic logic [31:0] m_wdata(op_t o);
    if (o.size >= 2) return o.sd;
    if (o.size == 1) return (o.sd % 65536) * 32'h00010001;
    return (o.sd % 256) * 32'h01010101;
  endfunction
  function automatic logic [31:0] m_load(op_t o, logic [31:0] rd);
    int bits;
    logic [31:0] v;
    if (o.size >= 2) return rd;
    bits = (o.size == 1) ? 16 : 8;
    v = (rd >> (8 * (align(o) % 4))) % (32'd1 << bits);
    if (o.sgn && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic drive(input op_t o);
    control_load_i = o.ld; control_store_i = o.st; size_i = o.size; signed_i = o.sgn;
    do_wb_i = o.wb; alu_i = o.alu; store_data_i = o.sd; wb_reg_i = o.rg;
  endtask

  vec_t vt[9];
  op_t idle, cur, nx;
  bit busy, exp_to, exp_st, exp_wb;
  int waited;

  initial begin
    idle = mkop(0, 0, 0, 0, 0, 0, 0, 0);
    vt[0] = mkv(mkop(0, 0, 2, 0, 1, 32'h1234, 0, 5), 0, 0, 0, 0, 0, 0, 32'h1234);
    vt[1] = mkv(mkop(1, 0, 0, 0, 1, 32'h101, 0, 1), 32'h11223344, 1, 0, 32'h101, 4'b0010, 0, 32'h33);
    vt[2] = mkv(mkop(1, 0, 1, 1, 1, 32'h202, 0, 2), 32'h87651234, 1, 0, 32'h202, 4'b1100, 0, 32'hFFFF8765);
    vt[3] = mkv(mkop(1, 0, 1, 0, 1, 32'h200, 0, 3), 32'h0000F00D, 1, 0, 32'h200, 4'b0011, 0, 32'h0000F00D);
    vt[4] = mkv(mkop(1, 0, 2, 1, 1, 32'h300, 0, 4), 32'hDEADBEEF, 1, 0, 32'h300, 4'b1111, 0, 32'hDEADBEEF);
    vt[5] = mkv(mkop(0, 1, 0, 0, 1, 32'h403, 32'h000000A5, 6), 0, 1, 1, 32'h403, 4'b1000, 32'hA5A5A5A5, 0);
    vt[6] = mkv(mkop(0, 1, 2, 0, 1, 32'h500, 32'hCAFEF00D, 7), 0, 1, 1, 32'h500, 4'b1111, 32'hCAFEF00D, 0);
    vt[7] = mkv(mkop(1, 0, 0, 1, 1, 32'h100, 0, 8), 32'h0000007F, 1, 0, 32'h100, 4'b0001, 0, 32'h7F);
    vt[8] = mkv(mkop(1, 1, 2, 0, 1, 32'h600, 32'h5555AAAA, 9), 32'h13579BDF, 1, 0, 32'h600, 4'b1111, 0, 32'h13579BDF);
    drive(idle); mem_ack_i = 0; mem_rdata_i = 0;
    #1;
    chk("reset stall", stall_o, 0); chk("reset req", mem_req_o, 0); chk("reset do_wb", do_wb_o, 0);
    chk("reset bus_err", bus_err_o, 0); chk("reset wb_val", wb_val_o, 0); chk("reset wb_reg", wb_reg_o, 0);
    @(negedge clk); rst = 0;
    // table: capture, then one cycle with ack high (ignored in IDLE for non-memory ops)
    foreach (vt[i]) begin
      @(negedge clk); drive(vt[i].o); mem_ack_i = 0;
      @(negedge clk); drive(idle); mem_ack_i = 1; mem_rdata_i = vt[i].rd;
      #1;
      chk($sformatf("vec%0d req", i), mem_req_o, vt[i].req);
      if (vt[i].req) begin
        chk($sformatf("vec%0d we", i), mem_we_o, vt[i].we);
        chk($sformatf("vec%0d addr", i), mem_addr_o, vt[i].addr);
        chk($sformatf("vec%0d be", i), mem_be_o, vt[i].be);
        if (vt[i].we) chk($sformatf("vec%0d wdata", i), mem_wdata_o, vt[i].wdata);
      end
      chk($sformatf("vec%0d stall", i), stall_o, 0);
      chk($sformatf("vec%0d do_wb", i), do_wb_o, 1);
      chk($sformatf("vec%0d wb_reg", i), wb_reg_o, vt[i].o.rg);
      chk($sformatf("vec%0d wb_val", i), wb_val_o, vt[i].val);
    end
    @(negedge clk); mem_ack_i = 0;
    // signed byte load, three wait cycles
    @(negedge clk); drive(mkop(1, 0, 0, 1, 1, 32'h103, 0, 7));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(idle); #1;
      chk("sb wait stall", stall_o, 1); chk("sb wait be", mem_be_o, 4'b1000); chk("sb wait do_wb", do_wb_o, 0);
    end
    @(negedge clk); mem_ack_i = 1; mem_rdata_i = 32'h80FFFFFF; #1;
    chk("sb ack stall", stall_o, 0); chk("sb ack val", wb_val_o, 32'hFFFFFF80); chk("sb ack do_wb", do_wb_o, 1);
    @(negedge clk); mem_ack_i = 0; #1;
    chk("sb after req", mem_req_o, 0);
    // half store, immediate ack
    @(negedge clk); drive(mkop(0, 1, 1, 0, 0, 32'h202, 32'h0000ABCD, 3));
    @(negedge clk); drive(idle); mem_ack_i = 1; #1;
    chk("sh req", mem_req_o, 1); chk("sh we", mem_we_o, 1); chk("sh be", mem_be_o, 4'b1100);
    chk("sh wdata", mem_wdata_o, 32'hABCDABCD); chk("sh stall", stall_o, 0); chk("sh do_wb", do_wb_o, 0);
    @(negedge clk); mem_ack_i = 0; #1;
    chk("sh one req", mem_req_o, 0);
    // timeout
    @(negedge clk); drive(mkop(1, 0, 2, 0, 1, 32'h500, 0, 9));
    for (int k = 0; k < TO; k++) begin
      @(negedge clk); drive(idle); #1;
      chk("to stall", stall_o, 1); chk("to bus_err early", bus_err_o, 0);
    end
    @(negedge clk); #1;
    chk("to bus_err", bus_err_o, 1); chk("to stall released", stall_o, 0); chk("to do_wb", do_wb_o, 0);
    @(negedge clk); #1;
    chk("to req drop", mem_req_o, 0); chk("to bus_err pulse", bus_err_o, 0);
    // misaligned word load
    @(negedge clk); drive(mkop(1, 0, 2, 0, 1, 32'h101, 0, 4));
    @(negedge clk); drive(idle); mem_ack_i = 1; mem_rdata_i = 32'h0BADF00D; #1;
`ifdef MISALIGN_TRAP_EN
    chk("mis pulse", misalign_o, 1); chk("mis req", mem_req_o, 0); chk("mis do_wb", do_wb_o, 0);
    @(negedge clk); mem_ack_i = 0; #1;
    chk("mis pulse end", misalign_o, 0);
`else
    chk("mis req", mem_req_o, 1); chk("mis addr", mem_addr_o, 32'h100); chk("mis be", mem_be_o, 4'b1111);
    chk("mis val", wb_val_o, 32'h0BADF00D);
    @(negedge clk); mem_ack_i = 0;
`endif
    // reset in the middle of an access
    @(negedge clk); drive(mkop(1, 0, 2, 0, 1, 32'h40, 0, 2));
    @(negedge clk); drive(idle); #1;
    chk("rst pre req", mem_req_o, 1);
    #2 rst = 1; #1;
    chk("rst async req", mem_req_o, 0); chk("rst async stall", stall_o, 0);
    @(negedge clk); rst = 0; mem_ack_i = 1; #1;
    chk("rst late ack req", mem_req_o, 0); chk("rst late ack do_wb", do_wb_o, 0); chk("rst late ack bus_err", bus_err_o, 0);
    // randomized run against the model (state after reset: nothing captured)
    cur = idle; busy = 0; waited = 0;
    for (int c = 0; c < 400; c++) begin
      int kind;
      @(negedge clk);
      kind = $urandom_range(0, 3);
      nx = mkop(kind == 1 || kind == 3, kind >= 2, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                $urandom, $urandom, 5'($urandom_range(0, 31)));
      drive(nx);
      mem_ack_i = ($urandom_range(0, 3) == 0);
      mem_rdata_i = $urandom;
      #1;
      exp_to = busy && !mem_ack_i && waited == TO;
      exp_st = busy && !mem_ack_i && !exp_to;
      exp_wb = cur.wb && !exp_st && !exp_to && !misal(cur);
      chk("rnd stall", stall_o, exp_st);
      chk("rnd req", mem_req_o, busy);
      chk("rnd bus_err", bus_err_o, exp_to);
      chk("rnd do_wb", do_wb_o, exp_wb);
      chk("rnd wb_reg", wb_reg_o, cur.rg);
`ifdef MISALIGN_TRAP_EN
      chk("rnd misalign", misalign_o, misal(cur));
`endif
      if (busy) begin
        chk("rnd we", mem_we_o, isst(cur));
        chk("rnd addr", mem_addr_o, align(cur));
        chk("rnd be", mem_be_o, m_be(cur));
        if (isst(cur)) chk("rnd wdata", mem_wdata_o, m_wdata(cur));
      end
      if (exp_wb) chk("rnd wb_val", wb_val_o, cur.ld ? m_load(cur, mem_rdata_i) : isst(cur) ? 32'd0 : cur.alu);
      if (!exp_st) begin
        cur = nx; busy = (nx.ld || nx.st) && !misal(nx); waited = 0;
      end else waited++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stage4_lsu.md
STAGE4_LSU -- requirements
Module: stage4_lsu

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the bus address width (range 3..32; low ADDR_WIDTH bits of alu_i are used).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the bus cycles to wait for ack before abort (range 1..255).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high: clk_i  in  1  clock; rst_i  in  1  reset.
REQ-004 The block SHALL have inputs: alu_i  in  32  ALU result or effective address; store_data_i  in  32  store source.
REQ-005 The block SHALL have inputs: control_load_i, control_store_i  in  1  op class; size_i  in  2  00 byte, 01 half, 10/11 word; signed_i  in  1  sign-extend load.
REQ-006 The block SHALL have inputs: do_wb_i  in  1  writeback request; wb_reg_i  in  5  destination register.
REQ-007 The block SHALL have output stall_o  out  1  hold upstream stages.
REQ-008 The block SHALL have bus outputs: mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  ADDR_WIDTH; mem_be_o  out  4; mem_wdata_o  out  32.
REQ-009 The block SHALL have bus inputs: mem_rdata_i  in  32; mem_ack_i  in  1.
REQ-010 The block SHALL have outputs: do_wb_o  out  1; wb_reg_o  out  5; wb_val_o  out  32; bus_err_o  out  1  timeout pulse.

Function
REQ-011 The block SHALL register all inputs at a clock edge only when stall_o is 0.
REQ-012 The block SHALL treat load and store asserted together as a load.
REQ-013 The block SHALL use an FSM with states IDLE and ACCESS; a captured load/store moves IDLE->ACCESS at the same edge.
REQ-014 In ACCESS, mem_req_o SHALL be 1 and mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o SHALL be held stable until ack or abort.
REQ-015 stall_o SHALL equal (state==ACCESS) && !mem_ack_i && !timeout; it SHALL be 0 in IDLE.
REQ-016 On an edge with ACCESS and mem_ack_i, the FSM SHALL return to IDLE, and the next instruction SHALL be captured at that edge.
REQ-017 The timeout counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack.
REQ-018 When the counter reaches TIMEOUT_CYCLES: release stall, pulse bus_err_o for that cycle, suppress do_wb_o, and return to IDLE.
REQ-019 Byte enables SHALL be: byte 0001<<addr[1:0]; half addr[1]?1100:0011; word 1111.
REQ-020 Store data SHALL be replicated across lanes: byte x4, half x2.
REQ-021 Load data SHALL be shifted right by addr[1:0]*8, then zero- or sign-extended (signed_i) from 8/16 bits; word is unmodified.
REQ-022 wb_val_o SHALL be: load -> extended mem_rdata_i, combinational in the ack cycle; store -> 0; otherwise -> registered alu_i.
REQ-023 do_wb_o SHALL be registered do_wb_i AND !stall_o AND not aborted; wb_reg_o SHALL be the registered wb_reg_i.
REQ-024 A non-memory op SHALL present its result in the cycle after capture with no stall.
REQ-025 mem_ack_i SHALL be ignored in IDLE.

Reset
REQ-026 Asserting rst_i SHALL immediately force: state IDLE, mem_req_o 0, stall_o 0, do_wb_o 0, bus_err_o 0, all registers 0, counter 0.
REQ-027 Reset during ACCESS SHALL abandon the access with no writeback and no bus_err_o.

Configuration
REQ-028 Macro MISALIGN_TRAP_EN: when defined, a misaligned load/store (half with addr[0]=1; word with addr[1:0]!=0) SHALL skip ACCESS, issue no bus request, and suppress do_wb_o.
REQ-029 With MISALIGN_TRAP_EN defined, a misaligned access SHALL pulse output misalign_o (out 1) for one cycle after capture.
REQ-030 Without MISALIGN_TRAP_EN, misalign_o SHALL NOT exist, and the address SHALL be aligned down (half: bit0=0; word: bits1:0=0) before the access proceeds.

Verification
REQ-031 ALU op alu_i=0x1234, do_wb_i=1, wb_reg_i=5 -> next cycle do_wb_o=1, wb_reg_o=5, wb_val_o=0x1234, stall_o=0.
REQ-032 Signed byte load addr 0x103, ack after 3 wait cycles, rdata 0x80FFFFFF -> stall_o=1 for 3 cycles, mem_be_o=1000, wb_val_o=0xFFFFFF80 in the ack cycle.
REQ-033 Half store addr 0x202, data 0x0000ABCD, immediate ack -> mem_we_o=1, mem_be_o=1100, mem_wdata_o=0xABCDABCD, one request cycle, do_wb_o=0.
REQ-034 Load with no ack, TIMEOUT_CYCLES=4 -> stall_o high 4 cycles, then bus_err_o pulses once, mem_req_o drops, do_wb_o=0.
REQ-035 Word load addr 0x101 -> with MISALIGN_TRAP_EN: misalign_o pulse, no mem_req_o; without it: mem_addr_o=0x100, mem_be_o=1111.
REQ-036 Assert rst_i mid-ACCESS -> mem_req_o and stall_o drop without waiting for a clock edge; a late mem_ack_i is ignored.
